// File: rtl/stopwatch_counter.sv
// Stopwatch time base: divides clk into 10 ms ticks and accumulates mm:ss.cc,
// gated by the run/clear levels from the mode FSM.
module stopwatch_counter #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_on,
    input  logic       clr_on,
    output logic [6:0] cs,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic       tick_10ms,
    output logic       wrap,
    output logic [1:0] status
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_ZERO = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] prescaler;
    logic          advance;
    logic          tick_edge;
    logic          at_last_time;

    // NOTE: next state defaults to the current state before the case, so
    // every path assigns it and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_ZERO: if (!clr_on && run_on) state_next = ST_RUN;
            ST_RUN: begin
                if (clr_on)       state_next = ST_ZERO;
                else if (!run_on) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (clr_on)      state_next = ST_ZERO;
                else if (run_on) state_next = ST_RUN;
            end
            default: state_next = ST_ZERO;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_ZERO;
        else       state <= state_next;
    end

    assign status       = state;
    assign advance      = (state == ST_RUN) && !clr_on;
    assign tick_edge    = advance && (prescaler >= PRE_LAST);
    assign at_last_time = (cs >= 7'd99) && (sec >= 6'd59) && (min >= 6'd59);

    // Comparisons use >= so a corrupted counter falls back into range at the next carry.
    always_ff @(posedge clk) begin
        if (reset || clr_on) begin
            prescaler <= '0;
            cs        <= '0;
            sec       <= '0;
            min       <= '0;
            tick_10ms <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            tick_10ms <= tick_edge;
            wrap      <= tick_edge && at_last_time;
            if (advance) begin
                if (prescaler >= PRE_LAST) prescaler <= '0;
                else                       prescaler <= prescaler + 1'b1;
            end
            if (tick_edge) begin
                if (cs >= 7'd99) begin
                    cs <= '0;
                    if (sec >= 6'd59) begin
                        sec <= '0;
                        if (min >= 6'd59) min <= '0;
                        else              min <= min + 6'd1;
                    end else begin
                        sec <= sec + 6'd1;
                    end
                end else begin
                    cs <= cs + 7'd1;
                end
            end
        end
    end

endmodule
